// File: rtl/music_seq_mc.sv
// Multi-channel note sequencer: walks a ROM block of per-channel half-period
// divisors, one note step every TICK_DIV clocks, with loop, pause, abort and done.

module music_seq_tone #(
    parameter int DIV_W = 14
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] rom_div,
    output logic             buzz
);
    logic [DIV_W-1:0] note_div;
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            note_div <= '0;
            cnt      <= '0;
            buzz     <= 1'b0;
        end else if (load) begin
            note_div <= rom_div;
            cnt      <= rom_div - DIV_W'(1);
            buzz     <= 1'b0;
        end else if (clear) begin
            buzz <= 1'b0;
        end else if (run) begin
            // A zero divisor is a rest: silent, counter parked.
            if (note_div == '0) begin
                buzz <= 1'b0;
            end else if (cnt == '0) begin
                cnt  <= note_div - DIV_W'(1);
                buzz <= ~buzz;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end
endmodule

module music_seq_mc #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 12,
    parameter int DIV_W    = 14,
    parameter int TICK_DIV = 3000000
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         start_addr,
    input  logic [ADDR_W-1:0]         stop_addr,
    input  logic                      loop,
    input  logic                      pause,
    input  logic                      interrupt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [CHANNELS*DIV_W-1:0] rom_data,
    output logic [CHANNELS-1:0]       Buzz,
    output logic                      busy,
    output logic                      done
);
    localparam int TW = $clog2(TICK_DIV);
    // PLAY covers the note step minus the FETCH and LOAD cycles.
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 3);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, PAUSED} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc, start_q, stop_q, pc_next;
    logic              loop_q;
    logic [TW-1:0]     tick;
    logic              playing, run, note_end, finish, to_idle, load;

    assign rom_addr = pc;
    assign busy     = (state != IDLE);
    assign pc_next  = pc + ADDR_W'(1);
    assign playing  = (state == PLAY) || (state == PAUSED);
    assign run      = playing && !pause && !interrupt && !start;
    assign note_end = run && (tick == TICK_LAST);
    assign finish   = note_end && (pc_next == stop_q) && !loop_q;
    assign to_idle  = interrupt || (start && (start_addr == stop_addr)) || finish;
    assign load     = (state == LOAD) && !interrupt && !start;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_tone
        music_seq_tone #(.DIV_W(DIV_W)) u_tone (
            .Clock   (Clock),
            .Reset   (Reset),
            .load    (load),
            .run     (run),
            .clear   (to_idle),
            .rom_div (rom_data[k*DIV_W +: DIV_W]),
            .buzz    (Buzz[k])
        );
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            pc      <= '0;
            start_q <= '0;
            stop_q  <= '0;
            loop_q  <= 1'b0;
            tick    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (interrupt) begin
                state <= IDLE;
            end else if (start) begin
                pc      <= start_addr;
                start_q <= start_addr;
                stop_q  <= stop_addr;
                loop_q  <= loop;
                tick    <= '0;
                if (start_addr == stop_addr) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    state <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: state <= LOAD;
                    LOAD: begin
                        tick  <= '0;
                        state <= PLAY;
                    end
                    PLAY, PAUSED: begin
                        if (pause) begin
                            state <= PAUSED;
                        end else if (note_end) begin
                            tick <= '0;
                            if (pc_next != stop_q) begin
                                pc    <= pc_next;
                                state <= FETCH;
                            end else if (loop_q) begin
                                pc    <= start_q;
                                state <= FETCH;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            tick  <= tick + TW'(1);
                            state <= PLAY;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
